// File: rtl/bep_pkg.sv
// Shared definitions for the thermostat-frame decode path.
// Contents:
//   ctrl_state_t       controller states (IDLE, ARM, RECEIVE, CHECK)
//   ERR_*              error-cause codes reported on error_code
//   FRAME_BITS_DEFAULT decoded bits in one complete frame
//   *_W                widths of the counters and decoder fields
//   sat_inc            8-bit increment that sticks at 255
package bep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RECEIVE,
    ST_CHECK
  } ctrl_state_t;

  localparam int ERR_W = 3;

  localparam logic [ERR_W-1:0] ERR_NONE     = 3'd0;
  localparam logic [ERR_W-1:0] ERR_PREAMBLE = 3'd1;
  localparam logic [ERR_W-1:0] ERR_TYPE     = 3'd2;
  localparam logic [ERR_W-1:0] ERR_CONSTANT = 3'd3;
  localparam logic [ERR_W-1:0] ERR_LENGTH   = 3'd4;
  localparam logic [ERR_W-1:0] ERR_TIMEOUT  = 3'd5;
  localparam logic [ERR_W-1:0] ERR_ABORT    = 3'd6;

  localparam int FRAME_BITS_DEFAULT = 192;

  localparam int COUNT_W    = 8;
  localparam int PREAMBLE_W = 32;
  localparam int TYPE_W     = 16;
  localparam int CONSTANT_W = 32;
  localparam int ID_W       = 32;
  localparam int TEMP_W     = 16;
  localparam int STATE_W    = 8;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
    return (value == '1) ? value : value + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/frame_watchdog.sv
// Inactivity watchdog for frame reception.
// Counts enabled clocks since the last clear and flags when the count
// reaches TIMEOUT_CYCLES-1.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   clear         restart the count from zero (wins over enable)
//   enable        advance the count by one this clock
//   expired       count has reached TIMEOUT_CYCLES-1
module frame_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Holds at the terminal value so a stalled controller never wraps the flag away.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/frame_controller.sv
// Sequences the thermostat-frame decode path: arms the serial decoder at
// each transmission start, counts decoded bits, watches for stalls, checks
// the fixed fields of a complete frame and commits good payloads into a
// stable shadow register set.
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   transmission_begin    one-cycle frame-start pulse
//   bit_strobe            one-cycle pulse per decoded bit
//   full                  decoder holds a complete frame
//   preamble .. state     decoder fields
//   decoder_reset         one-cycle clear pulse to the decoder
//   busy                  controller is in ARM, RECEIVE or CHECK
//   frame_valid           one-cycle pulse when a frame is committed
//   frame_error           one-cycle pulse when a frame is rejected or aborted
//   error_code            cause of the most recent error
//   out_*                 payload of the last committed frame
//   frame_count           committed frames, saturating
//   error_count           errored frames, saturating
module frame_controller
  import bep_pkg::*;
#(
  parameter int                    FRAME_BITS        = FRAME_BITS_DEFAULT,
  parameter int                    TIMEOUT_CYCLES    = 4096,
  parameter logic [PREAMBLE_W-1:0] EXPECTED_PREAMBLE = 32'hAAAA_AAAA,
  parameter logic [TYPE_W-1:0]     EXPECTED_TYPE_1   = 16'h1234,
  parameter logic [TYPE_W-1:0]     EXPECTED_TYPE_2   = 16'h5678,
  parameter logic [CONSTANT_W-1:0] EXPECTED_CONSTANT = 32'hC0DE_0001
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  transmission_begin,
  input  logic                  bit_strobe,
  input  logic                  full,
  input  logic [PREAMBLE_W-1:0] preamble,
  input  logic [TYPE_W-1:0]     type_1,
  input  logic [TYPE_W-1:0]     type_2,
  input  logic [CONSTANT_W-1:0] constant,
  input  logic [ID_W-1:0]       thermostat_id,
  input  logic [TEMP_W-1:0]     room_temp,
  input  logic [TEMP_W-1:0]     set_temp,
  input  logic [STATE_W-1:0]    state,
  output logic                  decoder_reset,
  output logic                  busy,
  output logic                  frame_valid,
  output logic                  frame_error,
  output logic [ERR_W-1:0]      error_code,
  output logic [ID_W-1:0]       out_thermostat_id,
  output logic [TEMP_W-1:0]     out_room_temp,
  output logic [TEMP_W-1:0]     out_set_temp,
  output logic [STATE_W-1:0]    out_state,
  output logic [COUNT_W-1:0]    frame_count,
  output logic [COUNT_W-1:0]    error_count
);

  localparam logic [COUNT_W-1:0] FRAME_LEN = COUNT_W'(FRAME_BITS);

  ctrl_state_t        ctrl_state;
  logic [COUNT_W-1:0] bit_count;
  logic [COUNT_W-1:0] count_next;
  logic               length_wait;
  logic               wd_clear;
  logic               wd_enable;
  logic               wd_expired;
  logic [ERR_W-1:0]   rx_error;
  logic [ERR_W-1:0]   chk_error;

  // The watchdog only runs while receiving; every strobe restarts it.
  assign wd_clear  = (ctrl_state != ST_RECEIVE) || bit_strobe;
  assign wd_enable = (ctrl_state == ST_RECEIVE) && !bit_strobe;

  frame_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // Error decisions for the current clock. The strobe of this clock is
  // already folded into count_next so a final bit arriving with full counts.
  // length_wait remembers that the previous clock ended with a complete bit
  // count but no full, which makes a second such clock a length error.
  always_comb begin
    count_next = bit_count + COUNT_W'(bit_strobe);

    rx_error = ERR_NONE;
    if (transmission_begin) begin
      if (bit_count != '0) begin
        rx_error = ERR_ABORT;
      end
    end else if (wd_expired) begin
      rx_error = ERR_TIMEOUT;
    end else if (full ? (count_next != FRAME_LEN)
                      : (length_wait && (count_next >= FRAME_LEN))) begin
      rx_error = ERR_LENGTH;
    end

    chk_error = ERR_NONE;
    if (preamble != EXPECTED_PREAMBLE) begin
      chk_error = ERR_PREAMBLE;
    end else if ((type_1 != EXPECTED_TYPE_1) || (type_2 != EXPECTED_TYPE_2)) begin
      chk_error = ERR_TYPE;
    end else if (constant != EXPECTED_CONSTANT) begin
      chk_error = ERR_CONSTANT;
    end
  end

  // Controller FSM. All outputs are registered: busy and decoder_reset are
  // set from the state being entered so they line up with ARM/RECEIVE/CHECK.
  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_state        <= ST_IDLE;
      bit_count         <= '0;
      length_wait       <= 1'b0;
      decoder_reset     <= 1'b0;
      busy              <= 1'b0;
      frame_valid       <= 1'b0;
      frame_error       <= 1'b0;
      error_code        <= ERR_NONE;
      out_thermostat_id <= '0;
      out_room_temp     <= '0;
      out_set_temp      <= '0;
      out_state         <= '0;
      frame_count       <= '0;
      error_count       <= '0;
    end else begin
      decoder_reset <= 1'b0;
      frame_valid   <= 1'b0;
      frame_error   <= 1'b0;

      case (ctrl_state)
        ST_IDLE: begin
          if (transmission_begin) begin
            ctrl_state    <= ST_ARM;
            decoder_reset <= 1'b1;
            busy          <= 1'b1;
          end
        end

        ST_ARM: begin
          bit_count   <= '0;
          length_wait <= 1'b0;
          ctrl_state  <= ST_RECEIVE;
        end

        ST_RECEIVE: begin
          bit_count   <= count_next;
          length_wait <= !full && (count_next >= FRAME_LEN);
          if (rx_error != ERR_NONE) begin
            frame_error <= 1'b1;
            error_code  <= rx_error;
            error_count <= sat_inc(error_count);
          end
          // A restart wins over every other exit; with no bits collected yet
          // it is treated as a harmless duplicate start.
          if (transmission_begin) begin
            ctrl_state    <= ST_ARM;
            decoder_reset <= 1'b1;
          end else if (rx_error != ERR_NONE) begin
            ctrl_state <= ST_IDLE;
            busy       <= 1'b0;
          end else if (full) begin
            ctrl_state <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (chk_error != ERR_NONE) begin
            frame_error <= 1'b1;
            error_code  <= chk_error;
            error_count <= sat_inc(error_count);
          end else begin
            out_thermostat_id <= thermostat_id;
            out_room_temp     <= room_temp;
            out_set_temp      <= set_temp;
            out_state         <= state;
            frame_valid       <= 1'b1;
            frame_count       <= sat_inc(frame_count);
          end
          // A start arriving during the check is honoured right after it.
          if (transmission_begin) begin
            ctrl_state    <= ST_ARM;
            decoder_reset <= 1'b1;
          end else begin
            ctrl_state <= ST_IDLE;
            busy       <= 1'b0;
          end
        end

        default: begin
          ctrl_state <= ST_IDLE;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/frame_controller.md
Name: frame_controller

Overview:
Sequences the thermostat-frame decode path. It arms the serial decoder at each transmission start, counts decoded bits, and watches for timeouts. When a frame completes it checks the fixed fields (preamble, type, constant). Only frames that pass are committed into a stable shadow register set. Errors are flagged and counted, replacing the raw "all bits set" probes on the top-level outputs.

Parameters:
FRAME_BITS, 192, decoded bits per complete frame
TIMEOUT_CYCLES, 4096, clocks allowed between bit strobes while receiving
EXPECTED_PREAMBLE, 32'hAAAA_AAAA, required preamble field
EXPECTED_TYPE_1, 16'h1234, required type_1 field
EXPECTED_TYPE_2, 16'h5678, required type_2 field
EXPECTED_CONSTANT, 32'hC0DE_0001, required constant field

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
transmission_begin  in  1  one-cycle pulse from state_machine marking frame start
bit_strobe  in  1  one-cycle pulse per decoded bit (manchester_clock rising edge, synchronised)
full  in  1  serial_decode has shifted a complete frame
preamble  in  32  decoder field
type_1  in  16  decoder field
type_2  in  16  decoder field
constant  in  32  decoder field
thermostat_id  in  32  decoder field
room_temp  in  16  decoder field
set_temp  in  16  decoder field
state  in  8  decoder field
decoder_reset  out  1  one-cycle clear pulse to serial_decode
busy  out  1  high in ARM, RECEIVE, CHECK
frame_valid  out  1  one-cycle pulse on commit
frame_error  out  1  one-cycle pulse on any rejected/aborted frame
error_code  out  3  cause of the last error, held until the next error or reset
out_thermostat_id  out  32  last committed value
out_room_temp  out  16  last committed value
out_set_temp  out  16  last committed value
out_state  out  8  last committed value
frame_count  out  8  committed frames, saturating at 255
error_count  out  8  errored frames, saturating at 255

Behaviour:
- Reset: every output is 0, state goes to IDLE, bit counter and watchdog are 0. All outputs are registered.
- Error codes: 0 none, 1 preamble, 2 type, 3 constant, 4 length, 5 timeout, 6 abort.
- IDLE: waits for transmission_begin, then goes to ARM.
- ARM (one cycle): decoder_reset=1, bit counter and watchdog cleared, then goes to RECEIVE.
- RECEIVE:
  - Each bit_strobe increments the 8-bit bit counter and clears the watchdog.
  - With no strobe, the watchdog increments.
  - Exits, in priority order:
    (a) transmission_begin: abort if bit counter >0 (code 6), then ARM. If bit counter ==0, go to ARM silently with no error.
    (b) watchdog reaches TIMEOUT_CYCLES-1: code 5, then IDLE.
    (c) full=1 while bit counter !=FRAME_BITS, or bit counter reaches FRAME_BITS while full=0 for 2 consecutive cycles: code 4, then IDLE.
    (d) full=1 and bit counter ==FRAME_BITS: go to CHECK.
  - A bit_strobe arriving in the same cycle as full counts before the comparison.
- CHECK (one cycle): compares the inputs to the parameters. Priority is preamble > type (type_1 or type_2 mismatch) > constant.
  - Pass: copy the four payload fields to the out_* registers, frame_valid=1, frame_count+1 (saturating), then IDLE.
  - Fail: frame_error=1, error_code set, error_count+1 (saturating), then IDLE.
- transmission_begin in CHECK: the check completes first, then the controller goes to ARM next cycle instead of IDLE. The pulse is latched for one cycle.
- Every error exit asserts frame_error and increments error_count in the same cycle that error_code updates.
- Latency: frame_valid occurs 2 clocks after the cycle in which full and the final bit coincide (RECEIVE→CHECK, CHECK→commit).
- out_* registers never change except on a commit. A reset mid-frame clears everything and discards the partial frame.
- bit_strobe is ignored outside RECEIVE.

Decomposition:
- Shared package (bep_pkg): state enum (IDLE, ARM, RECEIVE, CHECK), error-code constants, the FRAME_BITS default, and field widths.
- One natural sub-module: frame_watchdog (counter with clear/enable and terminal flag, parameterised by TIMEOUT_CYCLES).

Test Plan:
- Good frame: transmission_begin, 192 strobes, full with matching fields (room_temp=16'h00D2) -> decoder_reset pulse 1 cycle after begin; frame_valid 2 cycles after full; out_room_temp=16'h00D2; frame_count=1; error_count=0.
- Bad preamble: preamble=32'hAAAA_AAAB, other fields good -> frame_error pulse, error_code=1, out_* unchanged, error_count=1. Repeat with preamble and type both wrong -> code stays 1.
- Short frame: full asserted after 100 strobes -> error_code=4, state IDLE, frame_count unchanged.
- Timeout: begin, 10 strobes, then silence for TIMEOUT_CYCLES clocks -> error_code=5 at cycle TIMEOUT_CYCLES-1; a later good frame commits normally.
- Abort/restart: second transmission_begin after 50 strobes -> error_code=6, decoder_reset pulses again, bit counter restarts; the following complete frame commits.
- Saturation and reset: 260 good frames -> frame_count=255. Assert reset during RECEIVE -> all outputs 0 next cycle and no frame_valid.
